// File: rtl/ird_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ird_seq_pkg
// Description : Shared DPM decode definitions: IRD sequencer states and
//               ROM-addressing constants.
// Revision    : 1.0
// ============================================================================
package ird_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_W1   = 3'd1,
    ST_D1   = 3'd2,
    ST_EXEC = 3'd3,
    ST_WX   = 3'd4,
    ST_DX   = 3'd5
  } ird_state_t;

  // Specifier mode nibble that selects register-mode addressing.
  localparam logic [3:0] REG_MODE_NIB = 4'h5;

  localparam int unsigned MAX_SPEC_DEFAULT = 6;

endpackage : ird_seq_pkg
`default_nettype wire

// File: rtl/ird_seq.sv
`default_nettype none
// ============================================================================
// Module      : ird_seq
// Description : Instruction-decode sequencer feeding the IRD1/IRDX dispatch
//               ROMs; captures opcode/specifier bytes and sequences dispatch.
// Revision    : 1.0
// ============================================================================
module ird_seq
  import ird_seq_pkg::*;
#(
  parameter int unsigned MAX_SPEC = MAX_SPEC_DEFAULT
) (
  input  logic       clk_h,
  input  logic       reset_h,
  input  logic [7:0] ib_byte_h,
  input  logic       ib_valid_h,
  output logic       ib_take_h,
  input  logic       ird1_req_h,
  input  logic       irdx_req_h,
  input  logic       abort_h,
  output logic [7:0] xbuf_h,
  output logic [7:0] ir_h,
  output logic [2:0] ird_ctr_h,
  output logic       ird1_h,
  output logic       ird1_l,
  output logic       en_ird_rom_h,
  output logic       reg_mode_h,
  output logic       ird_stall_h
);

  localparam logic [3:0] c_max_spec = 4'(MAX_SPEC);

  ird_state_t r_state;
  logic [7:0] r_xbuf;
  logic [7:0] r_ir;
  logic [2:0] r_ctr;
  logic       r_ird1;
  logic       r_en_rom;
  logic       r_reg_mode;

  logic       w_waiting;
  logic [3:0] w_ctr_inc;
  logic [2:0] w_ctr_next;

  assign w_waiting  = (r_state == ST_W1) || (r_state == ST_WX);
  assign w_ctr_inc  = {1'b0, r_ctr} + 4'd1;
  assign w_ctr_next = (w_ctr_inc >= c_max_spec) ? c_max_spec[2:0] : w_ctr_inc[2:0];

  // A byte is only popped when the capture edge will actually take it.
  assign ib_take_h   = w_waiting && ib_valid_h && !abort_h && !reset_h;
  assign ird_stall_h = w_waiting && !ib_valid_h;

  always_ff @(posedge clk_h) begin
    if (reset_h) begin
      r_state    <= ST_IDLE;
      r_xbuf     <= 8'h00;
      r_ir       <= 8'h00;
      r_ctr      <= 3'd0;
      r_ird1     <= 1'b0;
      r_en_rom   <= 1'b0;
      r_reg_mode <= 1'b0;
    end else begin
      r_ird1     <= 1'b0;
      r_en_rom   <= 1'b0;
      r_reg_mode <= 1'b0;
      if (abort_h) begin
        r_state <= ST_IDLE;
        r_ctr   <= 3'd0;
      end else begin
        // Dispatch-cycle outputs are set on the capture edge so they are registered.
        case (r_state)
          ST_IDLE: begin
            if (ird1_req_h) r_state <= ST_W1;
          end
          ST_EXEC: begin
            if (ird1_req_h)      r_state <= ST_W1;
            else if (irdx_req_h) r_state <= ST_WX;
          end
          ST_W1: begin
            if (ib_valid_h) begin
              r_xbuf   <= ib_byte_h;
              r_state  <= ST_D1;
              r_en_rom <= 1'b1;
              r_ird1   <= 1'b1;
            end
          end
          ST_D1: begin
            r_ir    <= r_xbuf;
            r_ctr   <= 3'd0;
            r_state <= ST_EXEC;
          end
          ST_WX: begin
            if (ib_valid_h) begin
              r_xbuf     <= ib_byte_h;
              r_state    <= ST_DX;
              r_en_rom   <= 1'b1;
              r_reg_mode <= (ib_byte_h[7:4] == REG_MODE_NIB);
            end
          end
          ST_DX: begin
            r_ctr   <= w_ctr_next;
            r_state <= ST_EXEC;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign xbuf_h       = r_xbuf;
  assign ir_h         = r_ir;
  assign ird_ctr_h    = r_ctr;
  assign ird1_h       = r_ird1;
  assign ird1_l       = ~r_ird1;
  assign en_ird_rom_h = r_en_rom;
  assign reg_mode_h   = r_reg_mode;

endmodule : ird_seq
`default_nettype wire

// File: tb/tb_ird_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_ird_seq
// Description : Scoreboard bench for ird_seq with directed dispatch vectors.
// Revision    : 1.0
// ============================================================================
module tb_ird_seq;

  localparam int MAX_SPEC = 6;

  logic       clk_h = 1'b0;
  logic       reset_h;
  logic [7:0] ib_byte_h;
  logic       ib_valid_h;
  logic       ib_take_h;
  logic       ird1_req_h;
  logic       irdx_req_h;
  logic       abort_h;
  logic [7:0] xbuf_h;
  logic [7:0] ir_h;
  logic [2:0] ird_ctr_h;
  logic       ird1_h;
  logic       ird1_l;
  logic       en_ird_rom_h;
  logic       reg_mode_h;
  logic       ird_stall_h;

  ird_seq #(.MAX_SPEC(MAX_SPEC)) dut (
    .clk_h        (clk_h),
    .reset_h      (reset_h),
    .ib_byte_h    (ib_byte_h),
    .ib_valid_h   (ib_valid_h),
    .ib_take_h    (ib_take_h),
    .ird1_req_h   (ird1_req_h),
    .irdx_req_h   (irdx_req_h),
    .abort_h      (abort_h),
    .xbuf_h       (xbuf_h),
    .ir_h         (ir_h),
    .ird_ctr_h    (ird_ctr_h),
    .ird1_h       (ird1_h),
    .ird1_l       (ird1_l),
    .en_ird_rom_h (en_ird_rom_h),
    .reg_mode_h   (reg_mode_h),
    .ird_stall_h  (ird_stall_h)
  );

  always #5 clk_h = ~clk_h;

  typedef struct {
    logic       ird1;
    logic [7:0] xbuf;
    logic       reg_mode;
    logic [2:0] ctr;
    logic [7:0] ir;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_on = 1'b0;

  logic [2:0] exp_ctr = 3'd0;
  logic [7:0] exp_ir  = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_h);
    #1;
  endtask

  // Monitor: pops one expectation per dispatch cycle, checks the post-dispatch
  // counter/IR one cycle later, and checks idle-output values otherwise.
  initial begin
    exp_t cur;
    bit   post_pend = 1'b0;
    bit   prev_en   = 1'b0;
    forever begin
      @(negedge clk_h);
      if (mon_on) begin
        if (post_pend) begin
          chk("post_ctr", {29'd0, ird_ctr_h}, {29'd0, cur.ctr});
          chk("post_ir", {24'd0, ir_h}, {24'd0, cur.ir});
          post_pend = 1'b0;
        end
        if (en_ird_rom_h) begin
          chk("en_not_back_to_back", {31'd0, prev_en}, 32'd0);
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_dispatch: got en=1 expected no dispatch at %0t", $time);
          end else begin
            cur = sb.pop_front();
            chk("disp_ird1_h", {31'd0, ird1_h}, {31'd0, cur.ird1});
            chk("disp_ird1_l", {31'd0, ird1_l}, {31'd0, ~cur.ird1});
            chk("disp_xbuf", {24'd0, xbuf_h}, {24'd0, cur.xbuf});
            chk("disp_reg_mode", {31'd0, reg_mode_h}, {31'd0, cur.reg_mode});
            post_pend = 1'b1;
          end
        end else begin
          chk("idle_ird1_h", {31'd0, ird1_h}, 32'd0);
          chk("idle_ird1_l", {31'd0, ird1_l}, 32'd1);
          chk("idle_reg_mode", {31'd0, reg_mode_h}, 32'd0);
        end
        prev_en = en_ird_rom_h;
      end
    end
  end

  // One request from EXEC/IDLE through capture and dispatch; gap = cycles
  // spent waiting with ib_valid_h low.
  task automatic issue(input bit r1, input bit rx, input logic [7:0] b, input int gap);
    exp_t e;
    if (r1) begin
      exp_ctr    = 3'd0;
      exp_ir     = b;
      e.ird1     = 1'b1;
      e.reg_mode = 1'b0;
    end else begin
      exp_ctr    = (int'(exp_ctr) + 1 >= MAX_SPEC) ? 3'(MAX_SPEC) : exp_ctr + 3'd1;
      e.ird1     = 1'b0;
      e.reg_mode = (b[7:4] == 4'h5);
    end
    e.xbuf = b;
    e.ctr  = exp_ctr;
    e.ir   = exp_ir;
    sb.push_back(e);
    ird1_req_h = r1;
    irdx_req_h = rx;
    ib_byte_h  = b;
    ib_valid_h = (gap == 0);
    tick();
    ird1_req_h = 1'b0;
    irdx_req_h = 1'b0;
    for (int i = 0; i < gap; i++) begin
      #1;
      chk("stall_high", {31'd0, ird_stall_h}, 32'd1);
      chk("no_take_while_stall", {31'd0, ib_take_h}, 32'd0);
      tick();
    end
    ib_valid_h = 1'b1;
    #1;
    chk("take_pulse", {31'd0, ib_take_h}, 32'd1);
    chk("stall_low", {31'd0, ird_stall_h}, 32'd0);
    tick();
    ib_valid_h = 1'b0;
    #1;
    chk("dispatch_latency_en", {31'd0, en_ird_rom_h}, 32'd1);
    chk("no_take_in_dispatch", {31'd0, ib_take_h}, 32'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_h    = 1'b1;
    ib_byte_h  = 8'h00;
    ib_valid_h = 1'b0;
    ird1_req_h = 1'b0;
    irdx_req_h = 1'b0;
    abort_h    = 1'b0;
    repeat (3) tick();
    reset_h = 1'b0;
    mon_on  = 1'b1;
    repeat (5) tick();
    chk("rst_xbuf", {24'd0, xbuf_h}, 32'd0);
    chk("rst_ir", {24'd0, ir_h}, 32'd0);
    chk("rst_ctr", {29'd0, ird_ctr_h}, 32'd0);
    chk("rst_ird1_h", {31'd0, ird1_h}, 32'd0);
    chk("rst_ird1_l", {31'd0, ird1_l}, 32'd1);
    chk("rst_en", {31'd0, en_ird_rom_h}, 32'd0);
    chk("rst_reg_mode", {31'd0, reg_mode_h}, 32'd0);
    chk("rst_take", {31'd0, ib_take_h}, 32'd0);
    chk("rst_stall", {31'd0, ird_stall_h}, 32'd0);

    // Opcode, then specifiers through counter saturation.
    issue(1'b1, 1'b0, 8'hD0, 0);
    issue(1'b0, 1'b1, 8'h51, 0);
    issue(1'b0, 1'b1, 8'hA2, 0);
    issue(1'b0, 1'b1, 8'h13, 3);
    issue(1'b0, 1'b1, 8'h5A, 0);
    issue(1'b0, 1'b1, 8'h24, 0);
    issue(1'b0, 1'b1, 8'h58, 1);
    issue(1'b0, 1'b1, 8'h6B, 0);
    issue(1'b0, 1'b1, 8'h5C, 0);
    chk("ctr_saturated", {29'd0, ird_ctr_h}, 32'd6);

    // Both requests together: opcode path wins.
    issue(1'b1, 1'b1, 8'h9C, 0);
    issue(1'b0, 1'b1, 8'h5F, 0);

    // Abort in WX with a valid byte present.
    irdx_req_h = 1'b1;
    ib_valid_h = 1'b1;
    ib_byte_h  = 8'h33;
    tick();
    irdx_req_h = 1'b0;
    abort_h    = 1'b1;
    #1;
    chk("abort_no_take", {31'd0, ib_take_h}, 32'd0);
    tick();
    abort_h = 1'b0;
    exp_ctr = 3'd0;
    #1;
    chk("abort_ctr", {29'd0, ird_ctr_h}, 32'd0);
    chk("abort_xbuf_held", {24'd0, xbuf_h}, 32'h5F);
    chk("abort_ir_held", {24'd0, ir_h}, 32'h9C);
    chk("abort_idle_no_stall", {31'd0, ird_stall_h}, 32'd0);

    // Specifier request in IDLE is ignored.
    irdx_req_h = 1'b1;
    ib_byte_h  = 8'h55;
    tick();
    irdx_req_h = 1'b0;
    #1;
    chk("idle_irdx_no_take", {31'd0, ib_take_h}, 32'd0);
    chk("idle_irdx_no_stall", {31'd0, ird_stall_h}, 32'd0);
    repeat (3) tick();
    ib_valid_h = 1'b0;
    chk("idle_irdx_xbuf", {24'd0, xbuf_h}, 32'h5F);

    issue(1'b1, 1'b0, 8'h7E, 0);

    // Reset while waiting for an opcode byte.
    ird1_req_h = 1'b1;
    tick();
    ird1_req_h = 1'b0;
    reset_h    = 1'b1;
    ib_valid_h = 1'b1;
    ib_byte_h  = 8'hEE;
    #1;
    chk("reset_no_take", {31'd0, ib_take_h}, 32'd0);
    tick();
    reset_h    = 1'b0;
    ib_valid_h = 1'b0;
    exp_ctr    = 3'd0;
    exp_ir     = 8'h00;
    #1;
    chk("reset_xbuf", {24'd0, xbuf_h}, 32'd0);
    chk("reset_ir", {24'd0, ir_h}, 32'd0);
    chk("reset_ctr", {29'd0, ird_ctr_h}, 32'd0);
    chk("reset_en", {31'd0, en_ird_rom_h}, 32'd0);
    tick();
    chk("reset_en_after", {31'd0, en_ird_rom_h}, 32'd0);

    issue(1'b1, 1'b0, 8'h42, 0);
    repeat (4) tick();
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_ird_seq
`default_nettype wire
